// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg: shared types for the bus_arbiter slice.
//   arb_state_t : arbiter FSM state (IDLE / ACCESS / RESP).
//   ST_*        : the same encodings as plain localparams, for code that
//                 compares raw state bits.
// The latched request record (bus_req_t) depends on the arbiter's N
// parameter, so it is declared inside bus_arbiter itself.
// -----------------------------------------------------------------------------
package bus_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        ACCESS = ST_ACCESS,
        RESP   = ST_RESP
    } arb_state_t;

endpackage

// File: rtl/bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter: combinational round-robin pick. Finds the first set request at
// or after i_ptr, wrapping modulo NUM_M.
//   i_req [NUM_M] requests    i_ptr [GW] search start
//   o_any         any request  o_idx [GW] granted index (0 when o_any=0)
//
// address_validation_unit: region/permission check for one access.
//   i_valid, i_addr [N], i_we  ->  o_err (no region hit, or permission denied)
// The lowest-numbered matching region decides the permissions.
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_M = 2,
    parameter int GW    = 1
) (
    input  logic [NUM_M-1:0] i_req,
    input  logic [GW-1:0]    i_ptr,
    output logic             o_any,
    output logic [GW-1:0]    o_idx
);
    always_comb begin
        int j;
        j     = 0;
        o_any = 1'b0;
        o_idx = '0;
        for (int i = 0; i < NUM_M; i++) begin
            j = int'(i_ptr) + i;
            if (j >= NUM_M) j = j - NUM_M;
            if (!o_any && i_req[j]) begin
                o_any = 1'b1;
                o_idx = GW'(j);
            end
        end
    end
endmodule

module address_validation_unit #(
    parameter int                     N        = 32,
    parameter int                     M        = 1,
    parameter logic [M-1:0][N-1:0]    ADDR_MAP = '0,
    parameter logic [M-1:0][N-1:0]    MASK_MAP = '0,
    parameter logic [M-1:0]           WO       = '0,
    parameter logic [M-1:0]           RO       = '0
) (
    input  logic         i_valid,
    input  logic [N-1:0] i_addr,
    input  logic         i_we,
    output logic         o_err
);
    always_comb begin
        logic hit;
        logic deny;
        hit  = 1'b0;
        deny = 1'b0;
        // Walk downwards so the lowest matching region overrides the others.
        for (int r = M - 1; r >= 0; r--) begin
            if ((i_addr & MASK_MAP[r]) == (ADDR_MAP[r] & MASK_MAP[r])) begin
                hit  = 1'b1;
                deny = (RO[r] & i_we) | (WO[r] & ~i_we);
            end
        end
        o_err = i_valid & (~hit | deny);
    end
endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter: shares one slave bus between NUM_M requesters, round-robin,
// with region checking, one outstanding slave transaction and a watchdog.
//   i_clk, i_rst (sync, active-high)
//   i_m_req/addr/we/wdata/be   requester side inputs (held until ack)
//   o_m_ack/o_m_err/o_m_rdata  one-cycle response to the granted requester
//   o_s_valid/addr/we/wdata/be slave request, stable while in ACCESS
//   i_s_ready/i_s_rdata        slave completion
//   o_busy                     FSM not in IDLE
// Handshake: a requester holds i_m_req until it sees its o_m_ack pulse; the
// slave completes a transfer by raising i_s_ready in any cycle o_s_valid is
// high, and i_s_rdata is taken in that same cycle.
// -----------------------------------------------------------------------------
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int                     N        = 32,
    parameter int                     NUM_M    = 2,
    parameter int                     M        = 1,
    parameter logic [M-1:0][N-1:0]    ADDR_MAP = '0,
    parameter logic [M-1:0][N-1:0]    MASK_MAP = '0,
    parameter logic [M-1:0]           WO       = '0,
    parameter logic [M-1:0]           RO       = '0,
    parameter int                     TIMEOUT  = 255
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_M-1:0]            i_m_req,
    input  logic [NUM_M-1:0][N-1:0]     i_m_addr,
    input  logic [NUM_M-1:0]            i_m_we,
    input  logic [NUM_M-1:0][N-1:0]     i_m_wdata,
    input  logic [NUM_M-1:0][N/8-1:0]   i_m_be,
    output logic [NUM_M-1:0]            o_m_ack,
    output logic [NUM_M-1:0]            o_m_err,
    output logic [N-1:0]                o_m_rdata,
    output logic                        o_s_valid,
    output logic [N-1:0]                o_s_addr,
    output logic                        o_s_we,
    output logic [N-1:0]                o_s_wdata,
    output logic [N/8-1:0]              o_s_be,
    input  logic                        i_s_ready,
    input  logic [N-1:0]                i_s_rdata,
    output logic                        o_busy
);
    localparam int GW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN = (TIMEOUT > 0);
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef struct packed {
        logic [N-1:0]   addr;
        logic           we;
        logic [N-1:0]   wdata;
        logic [N/8-1:0] be;
    } bus_req_t;

    arb_state_t     state_q, state_d;
    logic [GW-1:0]  rr_q, rr_d;
    logic [GW-1:0]  g_q, g_d;
    bus_req_t       req_q, req_d;
    logic           err_q, err_d;
    logic [N-1:0]   rdata_q, rdata_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           any_req;
    logic [GW-1:0]  gnt_idx;
    logic           dec_err;

    rr_arbiter #(.NUM_M(NUM_M), .GW(GW)) u_rr (
        .i_req (i_m_req),
        .i_ptr (rr_q),
        .o_any (any_req),
        .o_idx (gnt_idx)
    );

    // Checked on the live requester inputs so a decode error answers in cycle 1.
    address_validation_unit #(
        .N(N), .M(M), .ADDR_MAP(ADDR_MAP), .MASK_MAP(MASK_MAP), .WO(WO), .RO(RO)
    ) u_avu (
        .i_valid (1'b1),
        .i_addr  (i_m_addr[gnt_idx]),
        .i_we    (i_m_we[gnt_idx]),
        .o_err   (dec_err)
    );

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        g_d     = g_q;
        req_d   = req_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    g_d   = gnt_idx;
                    req_d = '{addr:  i_m_addr[gnt_idx],  we: i_m_we[gnt_idx],
                              wdata: i_m_wdata[gnt_idx], be: i_m_be[gnt_idx]};
                    rr_d  = (gnt_idx == GW'(NUM_M - 1)) ? '0 : gnt_idx + 1'b1;
                    if (dec_err) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = '0;
                    end
                end
            end
            ACCESS: begin
                // A ready arriving in the timeout cycle still completes normally.
                if (i_s_ready) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    rdata_d = i_s_rdata;
                end else if (TO_EN && cnt_q == TO_LAST) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            g_q     <= '0;
            req_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            g_q     <= g_d;
            req_q   <= req_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        o_m_ack = '0;
        if (state_q == RESP) o_m_ack[g_q] = 1'b1;
    end

    assign o_m_err   = o_m_ack & {NUM_M{err_q}};
    assign o_m_rdata = (state_q == RESP) ? rdata_q : '0;

    // Slave outputs are held at zero outside ACCESS so the bus is quiet when idle.
    assign o_s_valid = (state_q == ACCESS);
    assign o_s_addr  = o_s_valid ? req_q.addr  : '0;
    assign o_s_we    = o_s_valid & req_q.we;
    assign o_s_wdata = o_s_valid ? req_q.wdata : '0;
    assign o_s_be    = o_s_valid ? req_q.be    : '0;
    assign o_busy    = (state_q != IDLE);

endmodule
